tx_block_serializer: RTL and testbench

TX_BLOCK_SERIALIZER -- requirements
Module: tx_block_serializer

---
 rtl/tx_block_serializer.sv | 139 +++++++++++++
 tb/tb_tx_block_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_block_serializer.sv
// tx_block_serializer
//
// Splits a wide input block into a sequence of narrower output beats.
// There are two block stages. The active stage is a shift register that
// feeds out_data. The pending stage buffers one more block, so a new block
// can be accepted while the current one is still draining.
//
// Ports
//   clk        rising-edge clock for all state
//   n_rst      asynchronous active-low reset
//   in_data    block to serialise (8*NUM_BYTES_IN bits)
//   in_valid   in_data is valid
//   in_ready   the block stage can take a block (combinational)
//   out_data   current beat (8*NUM_BYTES_OUT bits)
//   out_valid  out_data is valid
//   out_ready  consumer can take the beat
//   out_last   current beat is the final beat of its block
//   flush      synchronous abort of all held blocks
//   busy       a block is held (active or pending)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holding valid does not need to see ready first.
// in_ready is derived from the pending flag and flush only, not from in_valid.
// While out_valid is high and out_ready is low, out_data and out_last hold.

module tx_block_serializer #(
    parameter int NUM_BYTES_IN  = 16,
    parameter int NUM_BYTES_OUT = 8,
    parameter int MSB_FIRST     = 1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [8*NUM_BYTES_IN-1:0]  in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [8*NUM_BYTES_OUT-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    input  logic                       flush,
    output logic                       busy
);

    localparam int IW    = 8 * NUM_BYTES_IN;
    localparam int OW    = 8 * NUM_BYTES_OUT;
    localparam int BEATS = NUM_BYTES_IN / NUM_BYTES_OUT;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    generate
        if ((NUM_BYTES_OUT < 1) || (NUM_BYTES_IN < NUM_BYTES_OUT) ||
            ((NUM_BYTES_IN % NUM_BYTES_OUT) != 0)) begin : g_bad_params
            $error("tx_block_serializer: NUM_BYTES_IN must be a multiple of NUM_BYTES_OUT");
        end
    endgenerate

    logic [IW-1:0] active_reg;
    logic [IW-1:0] pending_reg;
    logic          active_valid;
    logic          pending_valid;
    logic [CW-1:0] count;
    logic [IW-1:0] active_shifted;

    logic accept;
    logic beat_xfer;
    logic last_beat;

    assign in_ready  = !pending_valid && !flush;
    assign accept    = in_valid && in_ready;
    assign beat_xfer = active_valid && out_ready;
    assign last_beat = (count == LAST_CNT);

    assign out_valid = active_valid;
    assign out_last  = active_valid && last_beat;
    assign busy      = active_valid || pending_valid;

    // The beat on out_data always sits at the output end of the active
    // register; each transfer shifts the next beat into that position.
    generate
        if (BEATS == 1) begin : g_single
            assign active_shifted = '0;
        end else if (MSB_FIRST != 0) begin : g_shift_msb
            assign active_shifted = {active_reg[IW-OW-1:0], {OW{1'b0}}};
        end else begin : g_shift_lsb
            assign active_shifted = {{OW{1'b0}}, active_reg[IW-1:OW]};
        end

        if (MSB_FIRST != 0) begin : g_out_msb
            assign out_data = active_reg[IW-1 -: OW];
        end else begin : g_out_lsb
            assign out_data = active_reg[OW-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active_reg    <= '0;
            pending_reg   <= '0;
            active_valid  <= 1'b0;
            pending_valid <= 1'b0;
            count         <= '0;
        end else if (flush) begin
            // Only the flags and counter are cleared; data is left stale.
            active_valid  <= 1'b0;
            pending_valid <= 1'b0;
            count         <= '0;
        end else if (beat_xfer && last_beat) begin
            // Block finishes: refill the active stage from pending, or
            // straight from the input when nothing is pending.
            if (pending_valid) begin
                active_reg    <= pending_reg;
                pending_valid <= 1'b0;
            end else if (accept) begin
                active_reg <= in_data;
            end else begin
                active_valid <= 1'b0;
            end
            count <= '0;
        end else begin
            if (beat_xfer) begin
                active_reg <= active_shifted;
                count      <= count + CW'(1);
            end
            if (accept) begin
                // A transfer here implies active is occupied, so the
                // block can only go direct to active when active is idle.
                if (!active_valid) begin
                    active_reg   <= in_data;
                    active_valid <= 1'b1;
                    count        <= '0;
                end else begin
                    pending_reg   <= in_data;
                    pending_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_block_serializer.sv
// tb_tx_block_serializer
//
// Drives three instances: default parameters, MSB_FIRST=0 on the same
// inputs, and an 8-in/8-out instance. A reference model keeps the
// expected beats of each held block in queues. It treats the block stages
// as a two-block FIFO; the expected in_ready, busy and out_valid come from
// how many blocks are held.

module tb_tx_block_serializer;

    localparam int BEATS = 2;
    localparam logic [127:0] SPEC_BLK = 128'h00112233445566778899AABBCCDDEEFF;

    // Clock and reset
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    // Default instance and the MSB_FIRST=0 instance share these inputs.
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         flush;
    logic         busy;

    logic         lsb_in_ready;
    logic [63:0]  lsb_out_data;
    logic         lsb_out_valid;
    logic         lsb_out_last;
    logic         lsb_busy;

    logic [63:0]  one_in_data;
    logic         one_in_valid;
    logic         one_in_ready;
    logic [63:0]  one_out_data;
    logic         one_out_valid;
    logic         one_out_ready;
    logic         one_out_last;
    logic         one_flush;
    logic         one_busy;

    tx_block_serializer dut (
        .clk(clk), .n_rst(n_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .flush(flush), .busy(busy)
    );

    tx_block_serializer #(.NUM_BYTES_IN(16), .NUM_BYTES_OUT(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .n_rst(n_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(lsb_in_ready),
        .out_data(lsb_out_data), .out_valid(lsb_out_valid), .out_ready(out_ready),
        .out_last(lsb_out_last), .flush(flush), .busy(lsb_busy)
    );

    tx_block_serializer #(.NUM_BYTES_IN(8), .NUM_BYTES_OUT(8)) dut_one (
        .clk(clk), .n_rst(n_rst),
        .in_data(one_in_data), .in_valid(one_in_valid), .in_ready(one_in_ready),
        .out_data(one_out_data), .out_valid(one_out_valid), .out_ready(one_out_ready),
        .out_last(one_out_last), .flush(one_flush), .busy(one_busy)
    );

    // Scoreboard: {last, beat} per expected beat, front = beat on the bus.
    logic [64:0] exp_q[$];
    logic [64:0] lsb_q[$];
    int          held;
    bit          acc_seen;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_update();
        logic acc;
        logic xf;
        acc = in_valid && (held < 2) && !flush;
        xf  = (held > 0) && out_ready;
        acc_seen = acc;
        if (flush) begin
            exp_q.delete();
            lsb_q.delete();
            held = 0;
        end else begin
            if (xf) begin
                if (exp_q[0][64]) held--;
                void'(exp_q.pop_front());
                void'(lsb_q.pop_front());
            end
            if (acc) begin
                for (int b = 0; b < BEATS; b++) begin
                    exp_q.push_back({b == BEATS - 1, 64'(in_data >> (64 * (BEATS - 1 - b)))});
                    lsb_q.push_back({b == BEATS - 1, 64'(in_data >> (64 * b))});
                end
                held++;
            end
        end
    endtask

    task automatic compare();
        logic exp_busy;
        exp_busy = (held > 0);
        check("out_valid", out_valid, exp_busy);
        check("busy", busy, exp_busy);
        check("in_ready", in_ready, (held < 2) && !flush);
        check("lsb_out_valid", lsb_out_valid, exp_busy);
        check("lsb_busy", lsb_busy, exp_busy);
        check("lsb_in_ready", lsb_in_ready, (held < 2) && !flush);
        if (held > 0) begin
            check("out_data", out_data, exp_q[0][63:0]);
            check("out_last", out_last, exp_q[0][64]);
            check("lsb_out_data", lsb_out_data, lsb_q[0][63:0]);
            check("lsb_out_last", lsb_out_last, lsb_q[0][64]);
        end
    endtask

    // Driver: inputs change at the falling edge, outputs checked there too.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        one_in_valid = 1'b0;
        n_rst    = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_lsb_out_valid", lsb_out_valid, 1'b0);
        check("rst_one_out_valid", one_out_valid, 1'b0);
        exp_q.delete();
        lsb_q.delete();
        held = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_out_valid", out_valid, 1'b0);
        check("rst_hold_out_data", out_data, 64'h0);
        n_rst = 1'b1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c_done;
        logic [63:0] prev;
        n_rst = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
        one_in_data = '0;
        one_in_valid = 1'b0;
        one_out_ready = 1'b1;
        one_flush = 1'b0;
        held = 0;
        @(negedge clk);
        do_reset();

        // Single block, both beat orders, known values.
        in_data = SPEC_BLK; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("blk_msb_beat0", out_data, 64'h0011223344556677);
        check("blk_msb_last0", out_last, 1'b0);
        check("blk_lsb_beat0", lsb_out_data, 64'h8899AABBCCDDEEFF);
        step();
        check("blk_msb_beat1", out_data, 64'h8899AABBCCDDEEFF);
        check("blk_msb_last1", out_last, 1'b1);
        check("blk_lsb_beat1", lsb_out_data, 64'h0011223344556677);
        check("blk_lsb_last1", lsb_out_last, 1'b1);
        step();
        check("blk_done_valid", out_valid, 1'b0);

        // Stalled consumer: A active, B pending, C waits.
        out_ready = 1'b0;
        in_data = SPEC_BLK; in_valid = 1'b1;
        step();
        in_data = rand128();
        step();
        in_data = rand128();
        step();
        check("stall_in_ready", in_ready, 1'b0);
        step();
        step();
        check("stall_hold_data", out_data, 64'h0011223344556677);
        check("stall_hold_last", out_last, 1'b0);
        out_ready = 1'b1;
        c_done = 1'b0;
        for (int i = 0; i < 10 && !c_done; i++) begin
            step();
            if (acc_seen) c_done = 1'b1;
        end
        in_valid = 1'b0;
        check("stall_c_accepted", c_done, 1'b1);
        for (int i = 0; i < 10 && held > 0; i++) step();
        check("stall_drained", out_valid, 1'b0);

        // Flush with the second beat outstanding and a block pending.
        in_data = rand128(); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = rand128();
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pre_flush_last", out_last, 1'b1);
        flush = 1'b1; in_valid = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("post_flush_valid", out_valid, 1'b0);
        check("post_flush_busy", busy, 1'b0);
        check("post_flush_in_ready", in_ready, 1'b1);
        in_data = rand128(); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_flush_first_last", out_last, 1'b0);
        step();
        step();

        // Reset mid-block.
        in_data = rand128(); in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        in_data = rand128(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_first_last", out_last, 1'b0);
        step();
        step();

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = rand128();
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // One beat per block: a block leaves every cycle.
        one_in_valid = 1'b1; one_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            one_in_data = {$urandom(), $urandom()};
            prev = one_in_data;
            step();
            check("one_out_valid", one_out_valid, 1'b1);
            check("one_out_last", one_out_last, 1'b1);
            check("one_out_data", one_out_data, prev);
            check("one_in_ready", one_in_ready, 1'b1);
            check("one_busy", one_busy, 1'b1);
        end
        one_in_valid = 1'b0;
        step();
        check("one_idle_valid", one_out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
